// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/ack handshake plus the core-side PC, instruction and status signals.
interface pc_fetch_unit_if;
  logic [31:0] next_pc;
  logic        pc_we;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pcp4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign;
  logic [31:0] retire_cnt;

  // The fetch unit is the master: it issues memory requests and drives the PC and status.
  modport master (
    input  next_pc, pc_we, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, pc, pcp4, instr, instr_valid, misalign, retire_cnt
  );

  modport slave (
    output next_pc, pc_we, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, pc, pcp4, instr, instr_valid, misalign, retire_cnt
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer: REQ -> VALID -> (REQ | FAULT).
// Holds imem_req/imem_addr until ack; a misaligned accepted target parks in FAULT until reset.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_unit_if.master bus
);

  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retire_q;
  logic        req_q;
  logic        valid_q;
  logic        mis_q;

  logic ack_taken;
  logic accept;

  // An ack only counts while a request is actually on the bus.
  assign ack_taken = (state == S_REQ) && req_q && bus.imem_ack;
  assign accept    = (state == S_VALID) && bus.pc_we && !bus.stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc_q     <= RST_PC;
      instr_q  <= 32'd0;
      retire_q <= 32'd0;
      req_q    <= 1'b1;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (ack_taken) begin
            instr_q <= bus.imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= S_VALID;
          end
        end
        S_VALID: begin
          if (accept) begin
            pc_q     <= bus.next_pc;
            retire_q <= retire_q + 32'd1;
            valid_q  <= 1'b0;
            if (bus.next_pc[1:0] == 2'b00) begin
              req_q <= 1'b1;
              state <= S_REQ;
            end else begin
              req_q <= 1'b0;
              mis_q <= 1'b1;
              state <= S_FAULT;
            end
          end
        end
        S_FAULT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          mis_q   <= 1'b1;
        end
        default: begin
          state   <= S_FAULT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          mis_q   <= 1'b1;
        end
      endcase
    end
  end

  // Request drops combinationally under reset so the memory never sees a stale fetch.
  assign bus.imem_req    = req_q && !rst;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.pcp4        = pc_q + 32'd4;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.misalign    = mis_q;
  assign bus.retire_cnt  = retire_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector table for the named scenarios, then randomized traffic against a behavioural model.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        pc_we;
    logic        stall;
    logic [31:0] next_pc;
    logic [31:0] e_pc;
    logic [31:0] e_pcp4;
    logic        e_req;
    logic        e_valid;
    logic        e_mis;
    logic [31:0] e_ret;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[$];

  // Behavioural reference: what the fetch unit holds, described by meaning rather than encoding.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_retired;
  bit          m_have_instr;
  bit          m_faulted;
  bit          use_model = 1'b0;

  task automatic add(input logic r, input logic a, input logic [31:0] rd, input logic we,
                     input logic st, input logic [31:0] np, input logic [31:0] epc,
                     input logic [31:0] ep4, input logic ereq, input logic eval,
                     input logic emis, input logic [31:0] eret, input logic [31:0] eins);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = rd; v.pc_we = we; v.stall = st; v.next_pc = np;
    v.e_pc = epc; v.e_pcp4 = ep4; v.e_req = ereq; v.e_valid = eval; v.e_mis = emis;
    v.e_ret = eret; v.e_instr = eins;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [31:0] rd, input logic we,
                       input logic st, input logic [31:0] np);
    rst            = r;
    bus.imem_ack   = a;
    bus.imem_rdata = rd;
    bus.pc_we      = we;
    bus.stall      = st;
    bus.next_pc    = np;
  endtask

  task automatic model_step();
    if (rst) begin
      m_pc = 32'h0000_3000; m_instr = 32'd0; m_retired = 32'd0;
      m_have_instr = 1'b0; m_faulted = 1'b0;
    end else if (m_faulted) begin
      // stuck until reset
    end else if (!m_have_instr) begin
      if (bus.imem_ack) begin
        m_instr = bus.imem_rdata;
        m_have_instr = 1'b1;
      end
    end else if (bus.pc_we && !bus.stall) begin
      m_retired = m_retired + 1;
      m_pc = bus.next_pc;
      m_have_instr = 1'b0;
      if (bus.next_pc % 4 != 0) m_faulted = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (use_model) model_step();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},          bus.pc,          m_pc);
    chk({tag, ".pcp4"},        bus.pcp4,        m_pc + 32'd4);
    chk({tag, ".imem_addr"},   bus.imem_addr,   m_pc);
    chk({tag, ".imem_req"},    {31'd0, bus.imem_req},
        {31'd0, (!rst && !m_have_instr && !m_faulted)});
    chk({tag, ".instr_valid"}, {31'd0, bus.instr_valid}, {31'd0, m_have_instr});
    chk({tag, ".misalign"},    {31'd0, bus.misalign},    {31'd0, m_faulted});
    chk({tag, ".retire_cnt"},  bus.retire_cnt,  m_retired);
    chk({tag, ".instr"},       bus.instr,       m_instr);
  endtask

  initial begin
    logic [31:0] np;
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    //  rst ack rdata          we st next_pc         pc             pcp4           req val mis ret instr
    add(1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 32'h0000_3004, 0, 0, 0, 0, 32'h0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 32'h0000_3004, 1, 0, 0, 0, 32'h0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 32'h0000_3004, 1, 0, 0, 0, 32'h0);
    add(0, 1, 32'h2008_0005, 0, 0, 32'h0,         32'h0000_3000, 32'h0000_3004, 0, 1, 0, 0, 32'h2008_0005);
    add(0, 0, 32'h0,         1, 1, 32'h0000_3004, 32'h0000_3000, 32'h0000_3004, 0, 1, 0, 0, 32'h2008_0005);
    add(0, 0, 32'h0,         1, 1, 32'h0000_3004, 32'h0000_3000, 32'h0000_3004, 0, 1, 0, 0, 32'h2008_0005);
    add(0, 0, 32'h0,         1, 0, 32'h0000_3004, 32'h0000_3004, 32'h0000_3008, 1, 0, 0, 1, 32'h2008_0005);
    add(0, 1, 32'h0000_0013, 1, 0, 32'hDEAD_0000, 32'h0000_3004, 32'h0000_3008, 0, 1, 0, 1, 32'h0000_0013);
    add(0, 0, 32'h0,         1, 0, 32'h0000_3040, 32'h0000_3040, 32'h0000_3044, 1, 0, 0, 2, 32'h0000_0013);
    add(0, 1, 32'h1111_1111, 0, 0, 32'h0,         32'h0000_3040, 32'h0000_3044, 0, 1, 0, 2, 32'h1111_1111);
    add(0, 0, 32'h0,         1, 0, 32'h0000_3042, 32'h0000_3042, 32'h0000_3046, 0, 0, 1, 3, 32'h1111_1111);
    add(0, 1, 32'hFFFF_FFFF, 1, 0, 32'h0000_3000, 32'h0000_3042, 32'h0000_3046, 0, 0, 1, 3, 32'h1111_1111);
    add(0, 1, 32'hFFFF_FFFF, 1, 0, 32'h0000_3000, 32'h0000_3042, 32'h0000_3046, 0, 0, 1, 3, 32'h1111_1111);
    add(1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 32'h0000_3004, 0, 0, 0, 0, 32'h0);
    add(0, 1, 32'h0000_0005, 0, 0, 32'h0,         32'h0000_3000, 32'h0000_3004, 0, 1, 0, 0, 32'h0000_0005);
    add(0, 0, 32'h0,         1, 0, 32'h0000_3100, 32'h0000_3100, 32'h0000_3104, 1, 0, 0, 1, 32'h0000_0005);
    add(1, 1, 32'hABCD_ABCD, 1, 0, 32'h0000_3200, 32'h0000_3000, 32'h0000_3004, 0, 0, 0, 0, 32'h0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 32'h0000_3004, 1, 0, 0, 0, 32'h0);
    add(0, 1, 32'h0000_0007, 0, 0, 32'h0,         32'h0000_3000, 32'h0000_3004, 0, 1, 0, 0, 32'h0000_0007);
    add(0, 0, 32'h0,         1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 0, 1, 32'h0000_0007);
    add(0, 1, 32'h0000_0009, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 0, 1, 0, 1, 32'h0000_0009);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ack, tbl[i].rdata, tbl[i].pc_we, tbl[i].stall, tbl[i].next_pc);
      tick();
      chk($sformatf("row%0d.pc", i),          bus.pc,          tbl[i].e_pc);
      chk($sformatf("row%0d.pcp4", i),        bus.pcp4,        tbl[i].e_pcp4);
      chk($sformatf("row%0d.imem_addr", i),   bus.imem_addr,   tbl[i].e_pc);
      chk($sformatf("row%0d.imem_req", i),    {31'd0, bus.imem_req},    {31'd0, tbl[i].e_req});
      chk($sformatf("row%0d.instr_valid", i), {31'd0, bus.instr_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("row%0d.misalign", i),    {31'd0, bus.misalign},    {31'd0, tbl[i].e_mis});
      chk($sformatf("row%0d.retire_cnt", i),  bus.retire_cnt,  tbl[i].e_ret);
      chk($sformatf("row%0d.instr", i),       bus.instr,       tbl[i].e_instr);
    end

    // Fault persistence: many stray acks and pc_we pulses must not disturb FAULT.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_3001);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, k[0], 32'h5A5A_0000 + 32'(k), 1'b1, k[1], 32'h0000_3000);
      tick();
      chk($sformatf("fault%0d.misalign", k), {31'd0, bus.misalign},    32'd1);
      chk($sformatf("fault%0d.imem_req", k), {31'd0, bus.imem_req},    32'd0);
      chk($sformatf("fault%0d.valid", k),    {31'd0, bus.instr_valid}, 32'd0);
      chk($sformatf("fault%0d.pc", k),       bus.pc,                   32'h0000_3001);
      chk($sformatf("fault%0d.retire", k),   bus.retire_cnt,           32'd2);
    end

    use_model = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      np = $urandom();
      case ($urandom_range(0, 15))
        0:       ;
        1:       np = 32'hFFFF_FFFC;
        default: np[1:0] = 2'b00;
      endcase
      drive((i == 0) || ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 9) < 4),
            $urandom(),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) < 3),
            np);
      tick();
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
